// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package irq_pkg;

    // Sequencer states, in the order they are walked on entry.
    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StPushPch,
        StPushPcl,
        StPushCcr,
        StRdVech,
        StRdVecl,
        StLoad
    } irq_state_e;

    // Stack push order. RTI pops in reverse: CCR, then PC low, then PC high.
    typedef enum logic [1:0] {
        PushPch  = 2'd0,
        PushPcl  = 2'd1,
        PushCcr  = 2'd2,
        PushNone = 2'd3
    } push_slot_e;

    localparam logic [11:0] VEC_ADDR_DEFAULT = 12'h000;

    // Which stack slot a state writes, PushNone for non-push states.
    function automatic push_slot_e push_slot(irq_state_e st);
        push_slot_e slot;
        case (st)
            StPushPch: slot = PushPch;
            StPushPcl: slot = PushPcl;
            StPushCcr: slot = PushCcr;
            default:   slot = PushNone;
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Data-memory requester port between the sequencer and the memory arbiter.
interface interrupt_sequencer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic              mem_use_sp;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_use_sp, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_use_sp, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata
    );
endinterface

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on the interrupt line feeding a one-deep pending flag.
module irq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic clear_i,
    output logic pending_o
);
    logic irq_q, irq_d;
    logic pending_q, pending_d;
    logic rise;

    // Next-state: a fresh edge wins over a same-cycle clear so it is not lost.
    always_comb begin
        rise      = irq_i & ~irq_q;
        irq_d     = irq_i;
        pending_d = pending_q;
        if (clear_i) pending_d = 1'b0;
        if (rise)    pending_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry: drain the pipe, push PC/CCR, fetch the vector, redirect PC.
module interrupt_sequencer
    import irq_pkg::*;
#(
    parameter int unsigned       PC_W         = 32,
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       ADDR_W       = 12,
    parameter int unsigned       CCR_W        = 3,
    parameter logic [ADDR_W-1:0] VEC_ADDR     = VEC_ADDR_DEFAULT,
    parameter int unsigned       DRAIN_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   interrupt,
    input  logic                   cu_busy,
    input  logic                   rti_done,
    input  logic [PC_W-1:0]        pc_next,
    input  logic [CCR_W-1:0]       ccr_in,
    output logic                   fetch_stall,
    output logic                   flush_ifid,
    output logic                   pc_load,
    output logic [PC_W-1:0]        pc_load_value,
    output logic                   in_service,
    interrupt_sequencer_if.master  mem
);
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    irq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   saved_pc_q, saved_pc_d;
    logic [CCR_W-1:0]  saved_ccr_q, saved_ccr_d;
    logic [DATA_W-1:0] vec_hi_q, vec_hi_d;
    logic [DATA_W-1:0] vec_lo_q, vec_lo_d;
    logic              in_service_q, in_service_d;
    logic              pending;
    logic              entry;

    irq_edge_latch u_edge (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (interrupt),
        .clear_i   (entry),
        .pending_o (pending)
    );

    assign entry = (state_q == StIdle) && pending && !cu_busy && !in_service_q;

    // Next-state and captured-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        saved_pc_d   = saved_pc_q;
        saved_ccr_d  = saved_ccr_q;
        vec_hi_d     = vec_hi_q;
        vec_lo_d     = vec_lo_q;
        in_service_d = in_service_q;
        if (rti_done) in_service_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (entry) begin
                    state_d    = StDrain;
                    saved_pc_d = pc_next;
                    cnt_d      = CNT_LOAD;
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    // Flags are sampled only once older instructions have retired.
                    saved_ccr_d = ccr_in;
                    state_d     = StPushPch;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPushPch: if (mem.mem_gnt) state_d = StPushPcl;
            StPushPcl: if (mem.mem_gnt) state_d = StPushCcr;
            StPushCcr: if (mem.mem_gnt) state_d = StRdVech;
            StRdVech: begin
                if (mem.mem_gnt) begin
                    vec_hi_d = mem.mem_rdata;
                    state_d  = StRdVecl;
                end
            end
            StRdVecl: begin
                if (mem.mem_gnt) begin
                    vec_lo_d = mem.mem_rdata;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                in_service_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any sequence in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            saved_pc_q   <= '0;
            saved_ccr_q  <= '0;
            vec_hi_q     <= '0;
            vec_lo_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            saved_pc_q   <= saved_pc_d;
            saved_ccr_q  <= saved_ccr_d;
            vec_hi_q     <= vec_hi_d;
            vec_lo_q     <= vec_lo_d;
            in_service_q <= in_service_d;
        end
    end

    // Moore outputs decoded from state and captured registers.
    always_comb begin
        fetch_stall    = (state_q != StIdle);
        flush_ifid     = (state_q == StDrain) && (cnt_q == CNT_LOAD);
        pc_load        = (state_q == StLoad);
        pc_load_value  = (state_q == StLoad) ? PC_W'({vec_hi_q, vec_lo_q}) : '0;
        in_service     = in_service_q;

        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_use_sp = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;

        unique case (state_q)
            StPushPch, StPushPcl, StPushCcr: begin
                mem.mem_req    = 1'b1;
                mem.mem_we     = 1'b1;
                mem.mem_use_sp = 1'b1;
            end
            StRdVech: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = VEC_ADDR;
            end
            StRdVecl: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = VEC_ADDR + ADDR_W'(1);
            end
            default: ;
        endcase

        unique case (push_slot(state_q))
            PushPch: mem.mem_wdata = saved_pc_q[PC_W-1:DATA_W];
            PushPcl: mem.mem_wdata = saved_pc_q[DATA_W-1:0];
            PushCcr: mem.mem_wdata = DATA_W'(saved_ccr_q);
            default: mem.mem_wdata = '0;
        endcase
    end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Pipeline-level interrupt controller for the 5-stage RISC core. Latches an external interrupt request, then freezes fetch and drains instructions already in flight. It pushes the return PC (two 16-bit words) and the CCR onto the stack through the data-memory port, reads the 32-bit handler vector from data memory, and redirects the PC. It sits beside the decode control unit, driving the fetch-stage enable/selection path, and is a requester on the data-memory arbiter.

## Interface
Parameters:
- PC_W, 32, program counter width
- DATA_W, 16, memory word width
- ADDR_W, 12, data-memory address width
- CCR_W, 3, condition code width
- VEC_ADDR, 12'h000, data-memory address of vector high word (low word at VEC_ADDR+1)
- DRAIN_CYCLES, 3, cycles waited for in-flight instructions to clear EX/MEM/WB

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- interrupt  in  1  external request, edge-sensitive (rising edge)
- cu_busy  in  1  decode is mid multi-word/frozen instruction (ldm, call, ret, rti); entry is blocked
- rti_done  in  1  one-cycle pulse when RTI has restored PC/CCR
- pc_next  in  PC_W  address of next instruction to fetch
- ccr_in  in  CCR_W  current flags
- fetch_stall  out  1  hold PC and IF/ID
- flush_ifid  out  1  one-cycle bubble into IF/ID
- pc_load  out  1  one-cycle PC overwrite strobe
- pc_load_value  out  PC_W  handler address
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write (push), 0 = read
- mem_use_sp  out  1  address comes from stack pointer; stack unit post-decrements on granted write
- mem_addr  out  ADDR_W  explicit address when mem_use_sp=0
- mem_wdata  out  DATA_W  push data
- mem_gnt  in  1  arbiter grant; transfer completes in that cycle
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_gnt=1
- in_service  out  1  handler running, further entries masked

## Operation
- Rising edge of `interrupt` (registered previous value) sets `pending`. A second edge while `pending` is set is absorbed; the pending flag is one-deep.
- States: IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, RD_VECH, RD_VECL, LOAD.
- IDLE→DRAIN when pending && !cu_busy && !in_service. On that edge:
  - capture saved_pc = pc_next
  - clear pending
  - load the drain counter with DRAIN_CYCLES-1
- DRAIN: counter decrements each cycle. At 0, capture saved_ccr = ccr_in and go to PUSH_PCH.
- PUSH_PCH: write saved_pc[31:16], mem_use_sp=1.
- PUSH_PCL: write saved_pc[15:0], mem_use_sp=1.
- PUSH_CCR: write {13'b0, saved_ccr}, mem_use_sp=1.
- RD_VECH: read mem_addr=VEC_ADDR into vec_hi.
- RD_VECL: read VEC_ADDR+1 into vec_lo.
- Every memory state holds mem_req=1 with stable mem_we/addr/wdata until mem_gnt=1, then advances next edge.
- LOAD: pc_load=1, pc_load_value={vec_hi,vec_lo}; set in_service; →IDLE.
- in_service clears on rti_done. An interrupt edge arriving during service stays pending and is taken once in_service=0.
- rti_done and the IDLE→DRAIN entry in the same cycle cannot collide, because entry requires in_service=0.

## Timing
- Reset values: state=IDLE; pending, in_service, and all strobes = 0; mem_addr, mem_wdata, pc_load_value = 0; saved registers = 0.
- Reset mid-sequence aborts at once; a partially pushed stack is not repaired.
- All outputs are Moore (decoded from state/registers).
- fetch_stall=1 in every non-IDLE state, including LOAD.
- flush_ifid=1 only in the first DRAIN cycle.
- Edge at cycle N → pending at N+1 → DRAIN at N+2 (if not blocked).
- Minimum entry-to-pc_load latency with zero-wait grants = 1 (pending) + DRAIN_CYCLES + 5 memory states + 1 = 10 cycles for defaults.
- Fetch resumes the cycle after LOAD from the loaded PC.

## Structure
- Shared package `irq_pkg`:
  - state enum
  - push-order constants (PCH, PCL, CCR), which RTI pop logic also uses
  - VEC_ADDR default
- One natural sub-module, `irq_edge_latch`: sync edge detector plus the one-deep pending flag, with a clear input.

## Test plan
- Basic entry: pc_next=32'h0000_0123, ccr_in=3'b101, M[0]=16'h0000, M[1]=16'h0200, gnt always 1 → three pushes 16'h0000, 16'h0123, 16'h0005 with mem_use_sp=1. pc_load pulse with 32'h0000_0200 exactly 10 cycles after the edge.
- Blocking: assert interrupt while cu_busy=1 for 4 cycles → stays IDLE with pending=1 and fetch_stall=0. DRAIN begins the cycle after cu_busy falls.
- Grant wait states: mem_gnt low 2 cycles in PUSH_PCL → mem_wdata holds 16'h0123 steady, and no advance until the grant.
- Nesting: second edge during in_service → no entry. rti_done pulse → DRAIN starts 1 cycle later. A third edge during pending leaves a single entry.
- Reset mid-PUSH_CCR: rst=0 → all outputs 0 asynchronously and state IDLE. After release, no spurious entry without a new edge.
- Flush/stall shape: flush_ifid high for exactly one cycle. fetch_stall high from DRAIN through LOAD inclusive.
